// File: rtl/result_ascii_tx.sv
// Converts a 16-bit ALU result to decimal ASCII (optional '-', digits, CR, LF)
// and streams it byte by byte over a valid/ready link to a UART transmitter.
module result_ascii_tx (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [15:0] value,
  input  logic        is_signed,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, CONV, SIGN, DIGIT, CR, LF, FIN} state_t;

  state_t      state;
  logic        neg;
  logic [15:0] mag;
  logic [19:0] bcd;
  logic [4:0]  cnt;
  logic [2:0]  idx;
  logic [2:0]  first;
  logic        xfer;

  function automatic logic [19:0] dabble(input logic [19:0] b, input logic in);
    logic [19:0] t;
    t = b;
    for (int i = 0; i < 5; i++)
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    return {t[18:0], in};
  endfunction

  function automatic logic [7:0] digit_char(input logic [19:0] b, input logic [2:0] i);
    logic [3:0] d;
    case (i)
      3'd0:    d = b[3:0];
      3'd1:    d = b[7:4];
      3'd2:    d = b[11:8];
      3'd3:    d = b[15:12];
      default: d = b[19:16];
    endcase
    return {4'h3, d};
  endfunction

  // Most significant nonzero digit; digit 0 is always sent even when all are zero.
  always_comb begin
    first = 3'd0;
    for (int i = 1; i < 5; i++)
      if (bcd[4*i +: 4] != 4'd0) first = 3'(i);
  end

  assign xfer = tx_valid & tx_ready;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state    <= IDLE;
      neg      <= 1'b0;
      mag      <= '0;
      bcd      <= '0;
      cnt      <= 5'd16;
      idx      <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          neg   <= is_signed & value[15];
          mag   <= (is_signed & value[15]) ? (~value + 16'd1) : value;
          bcd   <= '0;
          cnt   <= 5'd16;
          state <= CONV;
        end
        CONV: begin
          bcd <= dabble(bcd, mag[15]);
          mag <= {mag[14:0], 1'b0};
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) state <= neg ? SIGN : DIGIT;
        end
        // SIGN and DIGIT spend one cycle loading the first byte; afterwards the
        // next byte is loaded on the transfer edge so bytes flow back to back.
        SIGN: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= 8'h2D;
          end else if (tx_ready) begin
            state   <= DIGIT;
            idx     <= first;
            tx_data <= digit_char(bcd, first);
          end
        end
        DIGIT: begin
          if (!tx_valid) begin
            idx      <= first;
            tx_data  <= digit_char(bcd, first);
            tx_valid <= 1'b1;
          end else if (tx_ready) begin
            if (idx == 3'd0) begin
              state   <= CR;
              tx_data <= 8'h0D;
            end else begin
              idx     <= idx - 3'd1;
              tx_data <= digit_char(bcd, idx - 3'd1);
            end
          end
        end
        CR: if (xfer) begin
          state   <= LF;
          tx_data <= 8'h0A;
        end
        LF: if (xfer) begin
          state    <= FIN;
          tx_valid <= 1'b0;
          tx_data  <= 8'h00;
          done     <= 1'b1;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_ascii_tx.sv
// Randomized bench for result_ascii_tx: expected byte streams come from a
// decimal-formatting model of the value, compared against captured transfers.
module tb_result_ascii_tx;
  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] value = '0;
  logic        is_signed = 1'b0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  result_ascii_tx dut (
    .clk(clk), .n_rst(n_rst), .start(start), .value(value), .is_signed(is_signed),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void build(input logic [15:0] v, input bit s);
    int    val;
    string str;
    exp_q.delete();
    val = s ? int'($signed(v)) : int'(v);
    if (val < 0) begin
      exp_q.push_back(8'h2D);
      val = -val;
    end
    str = $sformatf("%0d", val);
    for (int i = 0; i < str.len(); i++) exp_q.push_back(8'(str[i]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  // mode 0: ready always high, 1: random ready, 2: ready low 5 cycles per byte.
  // poke re-pulses start while busy; abort_at >= 0 resets after that many bytes.
  task automatic send(input logic [15:0] v, input bit s, input int mode, input bit poke,
                      input int abort_at);
    logic [7:0] got_q[$];
    int ndone = 0, lat = -1, done_k = -1, hold = 0;
    bit pv = 0, fin = 0;
    logic [7:0] pd = '0;
    build(v, s);
    @(negedge clk);
    value = v; is_signed = s; start = 1'b1; tx_ready = (mode == 0);
    @(negedge clk);
    start = 1'b0;
    chk("busy_on", busy, 1);
    for (int k = 0; k < 3000 && !fin; k++) begin
      if (poke) begin
        start = (k == 5 || k == 20);
        value = 16'($urandom);
        is_signed = 1'($urandom);
      end
      if (mode == 1)      tx_ready = 1'($urandom);
      else if (mode == 2) tx_ready = (hold >= 5);
      else                tx_ready = 1'b1;
      if (pv) begin
        chk("hold_valid", tx_valid, 1);
        chk("hold_data", tx_data, pd);
      end
      if (tx_valid && lat < 0) lat = k;
      if (done) begin ndone++; done_k = k; fin = 1; end
      pv = tx_valid && !tx_ready;
      pd = tx_data;
      if (tx_valid && tx_ready) begin got_q.push_back(tx_data); hold = 0; end
      else if (tx_valid) hold++;
      if (abort_at >= 0 && got_q.size() == abort_at) begin
        start = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1; #1;
        chk("abort_valid", tx_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_data", tx_data, 0);
        for (int i = 0; i < abort_at; i++) chk("abort_byte", got_q[i], exp_q[i]);
        repeat (3) @(negedge clk);
        n_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (tx_valid || done) chk("post_abort_quiet", {tx_valid, done}, 0);
        end
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!fin) chk("timeout", 0, 1);
    chk("done_count", ndone, 1);
    @(negedge clk);
    chk("busy_off", busy, 0);
    chk("done_off", done, 0);
    if (mode == 0) begin
      chk("latency", lat, 17);
      chk("done_at", done_k, 17 + exp_q.size());
    end
    chk("length", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("byte%0d_%h", i, v), got_q[i], exp_q[i]);
  endtask

  initial begin
    #1;
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    n_rst = 1'b0;
    send(16'h0000, 0, 0, 0, -1);
    send(16'h8000, 1, 0, 0, -1);
    send(16'h8000, 0, 0, 0, -1);
    send(16'hFFFF, 1, 0, 0, -1);
    send(16'hFFFF, 0, 0, 0, -1);
    send(16'h03E8, 0, 0, 0, -1);
    send(16'h000C, 0, 2, 0, -1);
    send(16'd1234, 0, 0, 1, -1);
    send(16'h8000, 1, 0, 0, 2);
    send(16'd5, 0, 0, 0, -1);
    for (int r = 0; r < 30; r++)
      send(16'($urandom), 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom), -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
